// File: rtl/histo_frame_sequencer.sv
// Frame-level sequencer for the greyscale histogram: gates pixel accumulation, sweeps
// all bins into the display/cumulative RAMs with a running sum, then clears the histogram.
module histo_frame_sequencer #(
  parameter int BINS   = 256,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 20,
  parameter int RD_LAT = 1
) (
  input  logic              iPclk,
  input  logic              iRst,
  input  logic              iFval,
  input  logic              iDval,
  input  logic              iEnable,
  input  logic [CNT_W-1:0]  iBin_q,
  output logic [ADDR_W-1:0] oRd_addr,
  output logic [ADDR_W-1:0] oWr_addr,
  output logic              oAcc_en,
  output logic              oCopy_wen,
  output logic [CNT_W-1:0]  oCum_val,
  output logic              oClr_wen,
  output logic              oBusy,
  output logic              oFrame_done,
  output logic              oOverrun,
  output logic [1:0]        oState
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_COPY  = 2'd2,
    S_CLEAR = 2'd3
  } state_t;

  // Counter is wide enough to span BINS+RD_LAT copy cycles.
  localparam int CW = ADDR_W + 2;
  localparam logic [CW-1:0]     BINS_C    = CW'(BINS);
  localparam logic [CW-1:0]     LAT_C     = CW'(RD_LAT);
  localparam logic [CW-1:0]     COPY_LAST = CW'(BINS + RD_LAT - 1);
  localparam logic [CW-1:0]     CLR_LAST  = CW'(BINS - 1);
  localparam logic [CW-1:0]     CNT_ONE   = CW'(1);
  localparam logic [ADDR_W-1:0] LAT_A     = ADDR_W'(RD_LAT);

  state_t           state_reg, state_next;
  logic [CW-1:0]    cnt_reg, cnt_next;
  logic [CNT_W-1:0] cum_reg, cum_next;
  logic             fval_d_reg;
  logic             armed_reg;
  logic             done_reg, done_next;
  logic             ovr_reg, ovr_next;

  logic             rise, fall, busy, rd_phase, wr_phase, clr_phase;
  logic [CNT_W:0]   sum_wide;
  logic [CNT_W-1:0] cum_sat;

  assign rise      = iFval & ~fval_d_reg;
  assign fall      = ~iFval & fval_d_reg;
  assign busy      = (state_reg == S_COPY) | (state_reg == S_CLEAR);
  assign rd_phase  = (state_reg == S_COPY) & (cnt_reg < BINS_C);
  assign wr_phase  = (state_reg == S_COPY) & (cnt_reg >= LAT_C);
  // armed_reg holds off the clear sweep until the first edge after reset release
  assign clr_phase = (state_reg == S_CLEAR) & armed_reg;

  assign sum_wide  = {1'b0, cum_reg} + {1'b0, iBin_q};
  assign cum_sat   = sum_wide[CNT_W] ? {CNT_W{1'b1}} : sum_wide[CNT_W-1:0];

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    cum_next   = cum_reg;
    done_next  = 1'b0;
    ovr_next   = rise & busy;
    case (state_reg)
      S_IDLE: begin
        if (rise & iEnable) state_next = S_ACCUM;
      end
      S_ACCUM: begin
        if (fall) begin
          state_next = S_COPY;
          cnt_next   = '0;
        end
      end
      S_COPY: begin
        if (wr_phase) cum_next = cum_sat;
        if (cnt_reg == COPY_LAST) begin
          state_next = S_CLEAR;
          cnt_next   = '0;
          cum_next   = '0;
        end else begin
          cnt_next = cnt_reg + CNT_ONE;
        end
      end
      S_CLEAR: begin
        if (armed_reg) begin
          if (cnt_reg == CLR_LAST) begin
            state_next = S_IDLE;
            cnt_next   = '0;
            done_next  = 1'b1;
          end else begin
            cnt_next = cnt_reg + CNT_ONE;
          end
        end
      end
      default: begin
        state_next = S_CLEAR;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge iPclk or posedge iRst) begin
    if (iRst) begin
      state_reg  <= S_CLEAR;
      cnt_reg    <= '0;
      cum_reg    <= '0;
      fval_d_reg <= 1'b0;
      armed_reg  <= 1'b0;
      done_reg   <= 1'b0;
      ovr_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      cum_reg    <= cum_next;
      fval_d_reg <= iFval;
      armed_reg  <= 1'b1;
      done_reg   <= done_next;
      ovr_reg    <= ovr_next;
    end
  end

  assign oAcc_en     = (state_reg == S_ACCUM) & iFval & iDval;
  assign oRd_addr    = rd_phase ? cnt_reg[ADDR_W-1:0] : '0;
  assign oCopy_wen   = wr_phase;
  assign oClr_wen    = clr_phase;
  assign oWr_addr    = wr_phase  ? (cnt_reg[ADDR_W-1:0] - LAT_A) :
                       clr_phase ? cnt_reg[ADDR_W-1:0] : '0;
  assign oCum_val    = wr_phase ? cum_sat : '0;
  assign oBusy       = busy;
  assign oFrame_done = done_reg;
  assign oOverrun    = ovr_reg;
  assign oState      = state_reg;

endmodule
